// File: rtl/wbu_txuart_pkg.sv
// Shared definitions for the debug-bus UART pair: frame state encoding and
// the default bit period, so transmitter and receiver stay in step.
package wbu_txuart_pkg;

    // Frame position of the serial engine.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_DATA  = 2'b10,
        TX_STOP  = 2'b11
    } uart_state_e;

    // Clocks per bit for 115200 baud from a 100 MHz system clock.
    localparam logic [23:0] CPB_115200_100MHZ = 24'd868;

    // Data bits per 8N1 frame.
    localparam int unsigned UART_DATA_BITS = 8;

    // Value loaded into the baud down-counter at the start of each bit period;
    // the period ends on the cycle the counter reads zero.
    function automatic logic [23:0] baud_reload(input logic [23:0] cpb);
        return cpb - 24'd1;
    endfunction

endpackage

// File: rtl/wbu_txuart_ff_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable
// value forced by the synchronous reset.
module ff_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Capture the asynchronous level, then give it a full cycle to settle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/wbu_txuart.sv
// 8N1 UART transmitter fed by the wishbone debug-bus bridge. One byte is taken
// whenever the bridge strobes and we are not busy; CTS (active low) only gates
// the acceptance of new bytes, never a frame already on the wire.
module wbu_txuart
    import wbu_txuart_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = CPB_115200_100MHZ
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    input  logic       i_cts_n,
    output logic       o_uart_tx,
    output logic       o_busy
);

    localparam logic [23:0] BAUD_RELOAD = baud_reload(CLOCKS_PER_BAUD);

    uart_state_e state_q, state_d;
    logic [23:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  sreg_q, sreg_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;

    logic        cts_sync_n_s;
    logic        accept_s;
    logic        baud_zero_s;

    ff_sync2 #(
        .RESET_VAL (1'b1)
    ) u_cts_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_cts_n),
        .o_q     (cts_sync_n_s)
    );

    assign accept_s    = i_wr && !busy_q;
    assign baud_zero_s = (baud_q == 24'd0);

    // Next-state, counter, shift register and the line/busy values for the
    // coming cycle; the line is computed from the next frame position so the
    // pin is driven purely from a flop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        sreg_d    = sreg_q;
        tx_d      = tx_q;
        case (state_q)
            TX_IDLE: begin
                if (accept_s) begin
                    state_d   = TX_START;
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = 3'd0;
                    sreg_d    = i_data;
                    tx_d      = 1'b0;
                end else begin
                    tx_d      = 1'b1;
                end
            end
            TX_START: begin
                if (baud_zero_s) begin
                    state_d   = TX_DATA;
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = 3'd0;
                    tx_d      = sreg_q[0];
                end else begin
                    baud_d    = baud_q - 24'd1;
                    tx_d      = 1'b0;
                end
            end
            TX_DATA: begin
                if (baud_zero_s) begin
                    sreg_d = {1'b0, sreg_q[7:1]};
                    baud_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = TX_STOP;
                        bit_idx_d = 3'd0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = sreg_q[1];
                    end
                end else begin
                    baud_d = baud_q - 24'd1;
                    tx_d   = sreg_q[0];
                end
            end
            TX_STOP: begin
                if (baud_zero_s) begin
                    // Counter is left at zero in IDLE, the same as after reset.
                    state_d = TX_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d  = baud_q - 24'd1;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d   = TX_IDLE;
                baud_d    = 24'd0;
                bit_idx_d = 3'd0;
                sreg_d    = 8'd0;
                tx_d      = 1'b1;
            end
        endcase
        // A registered busy keeps the bridge path short; it also stretches the
        // gap between frames by one cycle, which the bridge tolerates.
        busy_d = (state_d != TX_IDLE) || cts_sync_n_s;
    end

    // Frame state and output registers with synchronous reset; reset aborts
    // any frame in flight and returns the line to mark.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= TX_IDLE;
            baud_q    <= 24'd0;
            bit_idx_q <= 3'd0;
            sreg_q    <= 8'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            sreg_q    <= sreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign o_uart_tx = tx_q;
    assign o_busy    = busy_q;

endmodule

// File: doc/wbu_txuart.md
# wbu_txuart

Serial transmitter that drains the debug-bus byte stream onto a UART line. It sits directly downstream of the wishbone debug-bus bridge: it takes the bridge's transmit byte strobe and data, and returns the busy flag the bridge throttles on. It produces 8N1 frames at a fixed, parameter-set baud rate, with optional hardware flow control through a CTS input.

## Interface
- CLOCKS_PER_BAUD, 24'd868: clock cycles per bit period (868 gives 115200 baud at 100 MHz). Legal values are 2 to 2^24-1.
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wr  in  1  byte-valid strobe from the bus bridge (its tx_stb). The bridge holds it until the byte is accepted.
- i_data  in  8  byte to send (its tx_data). Sampled only on the accept cycle.
- i_cts_n  in  1  clear-to-send, active low, asynchronous. Tie to 0 when flow control is not used.
- o_uart_tx  out  1  serial line; idles high.
- o_busy  out  1  registered; when high, no byte is accepted. Feeds the bridge's tx_busy.

## Operation
- **Accept rule.** A byte is accepted on any cycle with i_wr && !o_busy. i_data is latched into an 8-bit shift register on that cycle.
- **States.** IDLE, START, DATA, STOP.
  - IDLE → START on accept.
  - START → DATA after CLOCKS_PER_BAUD cycles.
  - DATA → STOP after 8 bit periods.
  - STOP → IDLE after 1 bit period.
- **Baud counter.** 24-bit down-counter, loaded with CLOCKS_PER_BAUD-1 on every state entry and on every DATA bit advance. A period ends when the counter reads 0. No wrap-around is possible, since the counter is always reloaded before it would underflow.
- **DATA.** Bits are sent LSB first from a 3-bit bit index. The shift register shifts right at the end of each bit period. DATA → STOP when the index is 7 and the counter is 0.
- **o_uart_tx by state.** 1 in IDLE and STOP, 0 in START, shift-register bit 0 in DATA. It is driven from a register; no combinational path reaches the pin.
- **CTS.** i_cts_n passes through a 2-flop synchronizer, reset to 1. The synchronized value blocks acceptance only; a frame already in progress always completes.
- **o_busy.** Next value = (next_state != IDLE) || cts_sync_n.
- **i_wr while busy.** Ignored. No buffering and no error flag.
- **Reset** (synchronous, including mid-frame), required next-cycle values:
  - state IDLE, counter 0, bit index 0, shift register 0.
  - o_uart_tx 1 (the aborted frame is truncated).
  - o_busy 1; synchronizer flops 1.

## Timing
- Accept at cycle T gives:
  - Start bit on cycles T+1 .. T+CPB.
  - Data bit n on cycles T+1+(n+1)·CPB .. T+(n+2)·CPB.
  - Stop bit starting at T+1+9·CPB, held through T+10·CPB.
- o_busy is high from T+1 and returns low at T+10·CPB+1, provided CTS is clear.
- **Back-to-back bytes.** Earliest next accept is T+10·CPB+1, and its start bit begins at T+10·CPB+2. The effective stop bit between frames is therefore CPB+1 cycles. This is required and must not be optimized away.
- **CTS latency.** A change on i_cts_n reaches o_busy 3 cycles later: 2 synchronizer cycles plus the register. A CTS deassertion in the same cycle as an accept does not cancel that accept.
- **After reset release.** o_busy is low no earlier than the 3rd cycle after i_reset falls, with i_cts_n held low.

## Structure
- Shared package: the state encoding (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11) and the 115200-baud default constant, reused by the matching receiver.
- No sub-module is required.
- The CTS synchronizer is the one natural extraction, as ff_sync2 (2-flop, parameterized reset value), so the receiver path can reuse it.

## Test plan
- **Single byte.** CPB=4, i_cts_n=0, send 0x55 at cycle T.
  - Required: line 0 on T+1..T+4, then bits 1,0,1,0,1,0,1,0 for 4 cycles each.
  - Then high on T+37..T+40; o_busy falls at T+41.
- **Back-to-back.** CPB=4, send 0xA3 then 0x0F with i_wr held.
  - Required: the second start bit begins exactly at T+42.
  - Receiver model decodes 0xA3, 0x0F.
- **Busy rejection.** Pulse i_wr with data 0xFF mid-frame while sending 0x00.
  - Required: the frame carries 0x00, no extra frame follows, o_busy is unaffected.
- **CTS gating.** Hold i_cts_n=1 and assert i_wr with 0x41.
  - Required: o_busy stays 1 and the line stays high.
  - Drop i_cts_n at cycle C: accept occurs at C+3, frame 0x41 follows.
- **CTS mid-frame.** Raise i_cts_n during data bit 3.
  - Required: the frame completes intact and o_busy stays high afterward.
- **Reset mid-frame.** Assert i_reset during data bit 5.
  - Required: next cycle o_uart_tx=1, o_busy=1.
  - After release, a new byte 0xC4 is transmitted correctly.
